// File: rtl/point_in_box_filter_if.sv
// Point stream bundle for point_in_box_filter: one signed x/y/z word
// per transfer, valid/ready handshake, pt_last marks the end of a scan.
interface point_in_box_filter_if #(
    parameter int W = 16
);
    logic                pt_valid;
    logic                pt_ready;
    logic                pt_last;
    logic signed [W-1:0] pt_x;
    logic signed [W-1:0] pt_y;
    logic signed [W-1:0] pt_z;

    modport master (
        output pt_valid,
        output pt_last,
        output pt_x,
        output pt_y,
        output pt_z,
        input  pt_ready
    );

    modport slave (
        input  pt_valid,
        input  pt_last,
        input  pt_x,
        input  pt_y,
        input  pt_z,
        output pt_ready
    );
endinterface

// File: rtl/point_in_box_filter.sv
// Streams points through a 2-stage inclusive signed box test and sequences
// scan end (scan_done, acc_clr). Define BOX_Z_CHECK_EN to enable the z axis.
module point_in_box_filter #(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    point_in_box_filter_if.slave pt,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_addr,
    input  logic signed [W-1:0] cfg_data,
    output logic                in_box,
    output logic                in_ce,
    output logic                scan_done,
    output logic                acc_clr,
    output logic [15:0]         pt_cnt
);

    localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        CLR
    } state_t;

    state_t state;
    logic   ready;
    logic   xfer;

    logic signed [W-1:0] xmin;
    logic signed [W-1:0] xmax;
    logic signed [W-1:0] ymin;
    logic signed [W-1:0] ymax;

    logic s1_valid;
    logic s1_last;
    logic s1_in_x;
    logic s1_in_y;
    logic s1_in_z;
    logic s2_last;

    assign pt.pt_ready = ready;
    assign xfer        = pt.pt_valid & ready;

    // Bound registers; a write lands after the edge, so a point transferred
    // on the same cycle is still compared against the old bound.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xmin <= SMIN;
            xmax <= SMAX;
            ymin <= SMIN;
            ymax <= SMAX;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    xmin <= cfg_data;
                3'd1:    xmax <= cfg_data;
                3'd2:    ymin <= cfg_data;
                3'd3:    ymax <= cfg_data;
                default: ;
            endcase
        end
    end

`ifdef BOX_Z_CHECK_EN
    logic signed [W-1:0] zmin;
    logic signed [W-1:0] zmax;

    // z bounds and stage-1 z compare
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zmin    <= SMIN;
            zmax    <= SMAX;
            s1_in_z <= 1'b0;
        end else begin
            if (cfg_we && cfg_addr == 3'd4) zmin <= cfg_data;
            if (cfg_we && cfg_addr == 3'd5) zmax <= cfg_data;
            s1_in_z <= ($signed(pt.pt_z) >= zmin) &&
                       ($signed(pt.pt_z) <= zmax);
        end
    end
`else
    logic unused_z;
    assign unused_z = ^pt.pt_z;
    assign s1_in_z  = 1'b1;
`endif

    // Stage 1: per-axis compares plus accepted-valid and last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_in_x  <= 1'b0;
            s1_in_y  <= 1'b0;
        end else begin
            s1_valid <= xfer;
            s1_last  <= xfer & pt.pt_last;
            s1_in_x  <= ($signed(pt.pt_x) >= xmin) &&
                        ($signed(pt.pt_x) <= xmax);
            s1_in_y  <= ($signed(pt.pt_y) >= ymin) &&
                        ($signed(pt.pt_y) <= ymax);
        end
    end

    // Stage 2: combined result, gated so in_box is low without in_ce
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ce   <= 1'b0;
            in_box  <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            in_ce   <= s1_valid;
            in_box  <= s1_valid & s1_in_x & s1_in_y & s1_in_z;
            s2_last <= s1_valid & s1_last;
        end
    end

    // Scan sequencer with registered ready/pulse outputs and point count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            scan_done <= 1'b0;
            acc_clr   <= 1'b0;
            pt_cnt    <= 16'd0;
        end else begin
            scan_done <= 1'b0;
            acc_clr   <= 1'b0;
            if (xfer && pt_cnt != 16'hFFFF) begin
                pt_cnt <= pt_cnt + 16'd1;
            end
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        if (pt.pt_last) begin
                            state <= DRAIN;
                            ready <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (xfer && pt.pt_last) begin
                        state <= DRAIN;
                        ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (in_ce && s2_last) begin
                        state     <= DONE;
                        scan_done <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= CLR;
                    acc_clr <= 1'b1;
                    pt_cnt  <= 16'd0;
                end
                CLR: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_point_in_box_filter.sv
// Scoreboard bench for point_in_box_filter: expected in_box, latency and
// scan-end timing are queued at each transfer and checked on DUT output.
module tb_point_in_box_filter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    point_in_box_filter_if #(.W(16)) pif ();

    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic signed [15:0] cfg_data;
    logic               in_box;
    logic               in_ce;
    logic               scan_done;
    logic               acc_clr;
    logic [15:0]        pt_cnt;

    point_in_box_filter #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .pt        (pif),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_box    (in_box),
        .in_ce     (in_ce),
        .scan_done (scan_done),
        .acc_clr   (acc_clr),
        .pt_cnt    (pt_cnt)
    );

    typedef struct {
        bit box;
        bit last;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int n_last  = 0;
    int sd_seen = 0;
    int m_cnt   = 0;
    int m_done  = -1;
    int m_clr   = -1;
    int bx0, bx1, by0, by1, bz0, bz1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_model(int x, int y, int z);
        bit r;
        r = (x >= bx0) && (x <= bx1) && (y >= by0) && (y <= by1);
`ifdef BOX_Z_CHECK_EN
        r = r && (z >= bz0) && (z <= bz1);
`else
        if (z != z) r = 1'b0;
`endif
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_cnt  = 0;
            m_done = -1;
            m_clr  = -1;
            bx0 = -32768; bx1 = 32767;
            by0 = -32768; by1 = 32767;
            bz0 = -32768; bz1 = 32767;
        end else begin
            if (in_ce) begin
                if (exp_q.size() == 0) begin
                    check("in_ce_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("in_box", {31'd0, in_box}, {31'd0, e.box});
                    check("latency", cyc - e.cyc, 2);
                    if (e.last) begin
                        m_done = cyc + 1;
                        m_clr  = cyc + 2;
                    end
                end
            end else if (in_box) begin
                check("in_box_no_ce", {31'd0, in_box}, 0);
            end
            if (scan_done) sd_seen++;
            if (scan_done || cyc == m_done) begin
                check("scan_done", {31'd0, scan_done},
                      (cyc == m_done) ? 1 : 0);
                if (cyc == m_done) check("cnt_at_done", pt_cnt, m_cnt);
            end
            if (acc_clr || cyc == m_clr) begin
                check("acc_clr", {31'd0, acc_clr},
                      (cyc == m_clr) ? 1 : 0);
                if (cyc == m_clr) begin
                    check("cnt_at_clr", pt_cnt, 0);
                    m_cnt = 0;
                end
            end
            if (pif.pt_valid && pif.pt_ready) begin
                exp_q.push_back('{
                    in_model($signed(pif.pt_x), $signed(pif.pt_y),
                             $signed(pif.pt_z)),
                    pif.pt_last, cyc});
                if (m_cnt != 65535) m_cnt++;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0: bx0 = $signed(cfg_data);
                    3'd1: bx1 = $signed(cfg_data);
                    3'd2: by0 = $signed(cfg_data);
                    3'd3: by1 = $signed(cfg_data);
                    3'd4: bz0 = $signed(cfg_data);
                    3'd5: bz1 = $signed(cfg_data);
                    default: ;
                endcase
            end
        end
    end

    task automatic send(int x, int y, int z, bit last);
        pif.pt_valid = 1'b1;
        pif.pt_x     = x[15:0];
        pif.pt_y     = y[15:0];
        pif.pt_z     = z[15:0];
        pif.pt_last  = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pif.pt_ready) break;
        end
        if (!pif.pt_ready) check("ready_timeout", 0, 1);
        else if (last) n_last++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        pif.pt_valid = 1'b0;
        pif.pt_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(bit [2:0] a, int d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d[15:0];
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        int n;
        cfg_we       = 1'b0;
        cfg_addr     = 3'd0;
        cfg_data     = 16'sd0;
        pif.pt_valid = 1'b0;
        pif.pt_last  = 1'b0;
        pif.pt_x     = 16'sd0;
        pif.pt_y     = 16'sd0;
        pif.pt_z     = 16'sd0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, pif.pt_ready}, 1);
        check("rst_in_ce", {31'd0, in_ce}, 0);
        check("rst_in_box", {31'd0, in_box}, 0);
        check("rst_scan_done", {31'd0, scan_done}, 0);
        check("rst_acc_clr", {31'd0, acc_clr}, 0);
        check("rst_cnt", pt_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // default box, five back-to-back points
        for (int i = 1; i <= 5; i++) send(i * 7, -i * 300, i - 3, i == 5);
        idle(8);

        // ready held low through DRAIN, DONE, CLR
        send(1, 1, 1, 1'b1);
        pif.pt_last = 1'b0;
        pif.pt_x    = 16'sd2;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pif.pt_ready) break;
            n++;
        end
        check("ready_low_cycles", n, 4);
        @(posedge clk);
        #1;
        send(3, 3, 3, 1'b1);
        idle(8);

        // box x[-10,10] y[0,20] z[-5,5]
        wr(3'd0, -10);
        wr(3'd1, 10);
        wr(3'd2, 0);
        wr(3'd3, 20);
        wr(3'd4, -5);
        wr(3'd5, 5);
        wr(3'd6, 1234);
        send(10, 20, 5, 1'b0);
        send(11, 0, 0, 1'b0);
        send(-10, 0, -6, 1'b1);
        idle(8);

        // bound write coinciding with a transfer
        wr(3'd0, -32768);
        wr(3'd1, 32767);
        cfg_we   = 1'b1;
        cfg_addr = 3'd0;
        cfg_data = 16'sd100;
        send(50, 0, 0, 1'b0);
        cfg_we = 1'b0;
        send(50, 0, 0, 1'b1);
        idle(8);

        // inverted x bounds reject everything
        wr(3'd0, 5);
        wr(3'd1, -5);
        send(0, 0, 0, 1'b0);
        send(5, 0, 0, 1'b0);
        send(-5, 0, 0, 1'b1);
        idle(8);

        // reset with points in flight
        send(1, 1, 1, 1'b0);
        send(2, 2, 2, 1'b0);
        rst          = 1'b0;
        pif.pt_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_ce", {31'd0, in_ce}, 0);
        check("midrst_cnt", pt_cnt, 0);
        check("midrst_ready", {31'd0, pif.pt_ready}, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(6);
        @(negedge clk);
        check("post_rst_cnt", pt_cnt, 0);
        @(posedge clk);
        #1;

        // single-point scan straight from IDLE, bounds back to accept-all
        send(-32768, 32767, 100, 1'b1);
        idle(8);

        check("queue_empty", exp_q.size(), 0);
        check("scan_count", sd_seen, n_last);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/point_in_box_filter.md
POINT_IN_BOX_FILTER -- requirements
Module: point_in_box_filter

Interface
REQ-001 Parameter W, default 16, signed coordinate/bound width in bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 pt_valid  in  1  point word on pt_x/pt_y/pt_z is valid.
REQ-005 pt_ready  out  1  block accepts point; transfer when pt_valid and pt_ready are both high.
REQ-006 pt_last  in  1  qualifies the transferred point as last of the current scan.
REQ-007 pt_x, pt_y, pt_z  in  W each  signed point coordinates.
REQ-008 cfg_we  in  1  bound register write strobe.
REQ-009 cfg_addr  in  3  bound select: 0 xmin, 1 xmax, 2 ymin, 3 ymax, 4 zmin, 5 zmax; 6 and 7 ignored.
REQ-010 cfg_data  in  W  signed bound value.
REQ-011 in_box  out  1  point lies inside box; drives accumulator input A.
REQ-012 in_ce  out  1  in_box qualifier; drives accumulator ce.
REQ-013 scan_done  out  1  one-cycle pulse: downstream count is final.
REQ-014 acc_clr  out  1  one-cycle active-high pulse clearing the downstream accumulator.
REQ-015 pt_cnt  out  16  points accepted in the current scan.

Function
REQ-016 Inside test SHALL be inclusive and signed: min <= coord <= max on every enabled axis; min > max on any enabled axis yields in_box = 0 for all points.
REQ-017 Stage 1 SHALL register per-axis compare results and valid/last; stage 2 SHALL register the AND as in_box, with in_ce = delayed accepted-valid; latency exactly 2 cycles from transfer to in_ce.
REQ-018 in_box SHALL be 0 whenever in_ce is 0.
REQ-019 FSM states IDLE, RUN, DRAIN, DONE, CLR.
REQ-020 IDLE: pt_ready = 1; first transfer -> RUN, or -> DRAIN if it carries pt_last.
REQ-021 RUN: pt_ready = 1; transfer with pt_last -> DRAIN.
REQ-022 DRAIN: pt_ready = 0; remains until the last point's in_ce has been issued, then -> DONE on the next edge.
REQ-023 DONE: pt_ready = 0, scan_done = 1 for exactly one cycle (the cycle after the last in_ce); -> CLR.
REQ-024 CLR: pt_ready = 0, acc_clr = 1 for exactly one cycle, pt_cnt cleared to 0; -> IDLE.
REQ-025 pt_cnt SHALL increment on each transfer and saturate at 16'hFFFF.
REQ-026 Bound writes SHALL be accepted in any state; a write on cycle N applies to points transferred on cycle N+1 onward; points already in the pipeline keep prior results.
REQ-027 Back-to-back transfers every cycle SHALL be supported with no bubble.
REQ-028 pt_valid without pt_ready SHALL have no effect.

Reset
REQ-029 On rst low: FSM -> IDLE, pipeline valids cleared, pt_ready = 1, in_box = in_ce = scan_done = acc_clr = 0, pt_cnt = 0.
REQ-030 Bound registers reset to xmin/ymin/zmin = most negative value, xmax/ymax/zmax = most positive value (accept-all box).
REQ-031 Reset mid-scan SHALL discard in-flight points; no scan_done or acc_clr issued for the aborted scan.

Configuration
REQ-032 Macro BOX_Z_CHECK_EN defined: z axis compared per REQ-016, registers 4/5 writable.
REQ-033 Macro undefined: z compare logic and registers 4/5 absent, z treated as always inside, writes to 4/5 ignored, pt_z unused.

Verification
REQ-034 Default bounds, 5 points, last on 5th -> in_ce high 5 cycles with in_box = 1, scan_done 1 cycle after last in_ce, acc_clr next cycle, pt_cnt = 5 then 0.
REQ-035 Box x[-10,10] y[0,20] z[-5,5]; points (10,20,5), (11,0,0), (-10,0,-6) -> in_box 1, 0, 0 (last 1 only when BOX_Z_CHECK_EN undefined).
REQ-036 pt_last transfer, then pt_valid held high -> pt_ready low for DRAIN, DONE, CLR (4 cycles); next point accepted in IDLE.
REQ-037 Write xmin = 100 on same cycle as transfer of x = 50 -> that point in_box per old bound; next x = 50 -> in_box = 0.
REQ-038 rst low while 2 points in pipeline -> in_ce never asserts for them, no scan_done, pt_cnt = 0.
REQ-039 xmin = 5, xmax = -5, 3 points -> in_box = 0 on all 3 in_ce cycles.
